i3c_ibi_hj_arbiter: RTL
=======================

# i3c_ibi_hj_arbiter

Arbitrates the target's single in-band notification slot on the I3C bus between NUM_REQ internal in-band-interrupt (IBI) sources and the hot-join source. It gates requests with the ENEC/DISEC event enables and the dynamic-address state, and waits for bus-free before issuing. It sequences one request at a time to the I3C target engine, with ACK/NACK handling, bounded retry and drop reporting. It sits between the event sources and the I3C target engine, alongside the hot-join/DAA/broadcast-decode block that supplies its `cmd_*` and `da_assigned` inputs.

## Interface
Parameters:
- NUM_REQ, 4: number of IBI requesters (1..8).
- IDLE_CYCLES, 8: consecutive bus-free cycles required before issue; also the backoff length. Must be ≥1.
- MAX_RETRY, 3: NACKs tolerated before a request is dropped. Must be ≥1.
- TIMEOUT_CYCLES, 256: WAIT_DONE watchdog limit; used only with I3C_IBI_TIMEOUT_EN.

Ports (ID_W = $clog2(NUM_REQ+1)):
- clk  in  1  block clock.
- rst  in  1  asynchronous, active-high reset.
- ibi_req  in  NUM_REQ  level request per source; held until `ibi_gnt`/`ev_drop`.
- ibi_mdb  in  NUM_REQ*8  mandatory data byte per source; slice i belongs to source i.
- hj_event_req  in  1  level hot-join request.
- da_assigned  in  1  target holds a valid dynamic address.
- bus_free  in  1  synchronized SCL&SDA high.
- cmd_enec, cmd_disec  in  1  one-cycle broadcast-command pulses.
- cmd_data  in  8  event byte: bit0 = INT, bit3 = HJ.
- eng_done  in  1  engine finished the current attempt (pulse).
- eng_ack  in  1  valid with `eng_done`: 1 = ACK, 0 = NACK.
- eng_start  out  1  one-cycle issue pulse.
- eng_type  out  1  0 = IBI, 1 = hot-join; stable from `eng_start` through `eng_done`.
- eng_mdb  out  8  MDB of the winner (0 for hot-join); stable likewise.
- ibi_gnt  out  NUM_REQ  one-hot pulse on ACK of an IBI.
- hj_gnt  out  1  pulse on ACK of a hot-join.
- ev_drop  out  1  pulse when a request is abandoned.
- ev_drop_id  out  ID_W  index of the dropped source; NUM_REQ = hot-join.
- ibi_en, hj_en  out  1  current event enables.
- busy  out  1  state ≠ IDLE.

## Operation
- Enables:
  - `cmd_enec` sets `ibi_en` if cmd_data[0] = 1 and sets `hj_en` if cmd_data[3] = 1.
  - `cmd_disec` clears the same bits.
  - ENEC and DISEC in the same cycle: DISEC wins.
- Eligibility:
  - IBI i is eligible when `ibi_req[i] & ibi_en & da_assigned`.
  - Hot-join is eligible when `hj_event_req & hj_en & !da_assigned`.
- Priority: hot-join beats any IBI. IBIs use round-robin from the pointer `rr_ptr` (reset 0); after an ACK or drop of IBI i, `rr_ptr` becomes (i+1) mod NUM_REQ.
- idle_cnt: counts consecutive `bus_free` cycles and saturates at IDLE_CYCLES; `bus_free` = 0 clears it.
- States:
  - IDLE: if any source is eligible, latch the winner, its type and its MDB; clear retry_cnt; go to WAIT_FREE.
  - WAIT_FREE: if the winner becomes ineligible (request dropped, enable cleared, `da_assigned` toggled), go to IDLE with no gnt and no drop. Otherwise, when idle_cnt == IDLE_CYCLES, go to ISSUE.
  - ISSUE: `eng_start` = 1 for exactly this cycle; go to WAIT_DONE.
  - WAIT_DONE: wait for `eng_done`; enable or request changes are ignored here.
    - ACK: pulse `ibi_gnt[i]` or `hj_gnt`; go to IDLE.
    - NACK: retry_cnt += 1. If the new value == MAX_RETRY, pulse `ev_drop` with `ev_drop_id` and go to IDLE; otherwise go to BACKOFF.
  - BACKOFF: count IDLE_CYCLES cycles, then go to WAIT_FREE. The winner is kept; there is no re-arbitration.
- `eng_done` outside WAIT_DONE is ignored.

## Timing
- Reset values:
  - State IDLE; `eng_start`, `eng_type`, `eng_mdb`, `ibi_gnt`, `hj_gnt`, `ev_drop`, `ev_drop_id`, `busy` all 0.
  - `ibi_en` = 1, `hj_en` = 1; `rr_ptr`, retry_cnt and idle_cnt = 0.
- All outputs are registered.
- Latency with the bus already free: request seen at edge 0, WAIT_FREE at edge 1, `eng_start` high in the cycle after edge 2.
- Grant/drop pulse: asserted in the cycle after the edge that samples `eng_done`, and lasts 1 cycle.
- Enable update is visible 1 cycle after the `cmd_*` pulse.
- Reset mid-transaction returns the block to IDLE immediately. The engine sees `eng_start` low; outstanding attempts are discarded without gnt or drop.

## Configuration
- I3C_IBI_TIMEOUT_EN defined:
  - A watchdog counts cycles in WAIT_DONE.
  - Reaching TIMEOUT_CYCLES without `eng_done` is treated as a NACK; retry/drop rules apply.
  - `eng_done` in the same cycle as the timeout takes precedence.
- Not defined: no watchdog; WAIT_DONE waits indefinitely.

## Test plan
- NUM_REQ=4, da_assigned=1, bus free; assert ibi_req=4'b0101, ACK each attempt → grants in order `ibi_gnt`=0001, then 0100; second `eng_start` carries MDB slice 2.
- da_assigned=0; assert hj_event_req and ibi_req[1] → only hot-join issued with `eng_type`=1; after ACK, `hj_gnt` pulses and IBI 1 stays pending.
- IBI 3, NACK three times (MAX_RETRY=3) → three `eng_start`s, each ≥IDLE_CYCLES after the previous done; then `ev_drop`=1 with `ev_drop_id`=3 and no `ibi_gnt`.
- `cmd_disec` with cmd_data=8'h01 while in WAIT_FREE → return to IDLE with no `eng_start`; `cmd_enec` with 8'h01 → request reissued.
- `bus_free` drops at idle_cnt=5 → idle count restarts; `eng_start` occurs only after 8 consecutive free cycles.
- With the macro, withhold `eng_done` → NACK assumed after 256 cycles; assert `rst` mid-WAIT_DONE → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/i3c_ibi_hj_arbiter.sv
// Arbitrates the single I3C in-band notification slot between NUM_REQ IBI sources and hot-join.
// Latency: request sampled in IDLE -> WAIT_FREE next edge -> eng_start two edges later on a free bus.
// Backpressure: sources hold their level request until ibi_gnt/hj_gnt/ev_drop; the engine paces via eng_done.
// Optional build macro: I3C_IBI_TIMEOUT_EN adds a WAIT_DONE watchdog that turns a silent engine into a NACK.
module i3c_ibi_hj_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int IDLE_CYCLES    = 8,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int ID_W          = $clog2(NUM_REQ + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   ibi_req,
  input  logic [NUM_REQ*8-1:0] ibi_mdb,
  input  logic                 hj_event_req,
  input  logic                 da_assigned,
  input  logic                 bus_free,
  input  logic                 cmd_enec,
  input  logic                 cmd_disec,
  input  logic [7:0]           cmd_data,
  input  logic                 eng_done,
  input  logic                 eng_ack,
  output logic                 eng_start,
  output logic                 eng_type,
  output logic [7:0]           eng_mdb,
  output logic [NUM_REQ-1:0]   ibi_gnt,
  output logic                 hj_gnt,
  output logic                 ev_drop,
  output logic [ID_W-1:0]      ev_drop_id,
  output logic                 ibi_en,
  output logic                 hj_en,
  output logic                 busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IC_W  = $clog2(IDLE_CYCLES + 1);
  localparam int RC_W  = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FREE,
    S_ISSUE,
    S_WAIT_DONE,
    S_BACKOFF
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   win_ptr;
  logic               win_hj;
  logic [RC_W-1:0]    retry_cnt;
  logic [IC_W-1:0]    idle_cnt;
  logic [IC_W-1:0]    bo_cnt;

  logic [NUM_REQ-1:0] ibi_elig;
  logic               hj_elig;
  logic               rr_found;
  logic [PTR_W-1:0]   rr_sel;
  logic [7:0]         sel_mdb;
  logic               win_elig;
  logic [PTR_W-1:0]   rr_next;
  logic [RC_W-1:0]    retry_next;
  logic               attempt_nack;
  logic               unused_cmd_bits;

  // Only the INT and HJ bits of the event byte matter here.
  assign unused_cmd_bits = ^{cmd_data[7:4], cmd_data[2:1]};

`ifdef I3C_IBI_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_hit;
  assign wd_hit       = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  // A real eng_done in the timeout cycle wins over the watchdog.
  assign attempt_nack = (eng_done & ~eng_ack) | (~eng_done & wd_hit);
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign attempt_nack = eng_done & ~eng_ack;
`endif

  // Eligibility gating and round-robin search starting at rr_ptr.
  always_comb begin
    int idx;
    idx      = 0;
    ibi_elig = ibi_req & {NUM_REQ{ibi_en & da_assigned}};
    hj_elig  = hj_event_req & hj_en & ~da_assigned;
    rr_found = 1'b0;
    rr_sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!rr_found && ibi_elig[PTR_W'(idx)]) begin
        rr_found = 1'b1;
        rr_sel   = PTR_W'(idx);
      end
    end
  end

  // MDB of the round-robin candidate.
  always_comb begin
    sel_mdb = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (PTR_W'(k) == rr_sel) sel_mdb = ibi_mdb[k*8 +: 8];
    end
  end

  // Latched-winner helpers: is it still requesting, where the pointer goes next, retry step.
  always_comb begin
    win_elig   = win_hj ? hj_elig : ibi_elig[win_ptr];
    rr_next    = (win_ptr == PTR_W'(NUM_REQ - 1)) ? '0 : win_ptr + 1'b1;
    retry_next = retry_cnt + 1'b1;
  end

  // Saturating count of consecutive bus-free cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (!bus_free) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IC_W'(IDLE_CYCLES)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // ENEC/DISEC event enables; DISEC wins when both pulse together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ibi_en <= 1'b1;
      hj_en  <= 1'b1;
    end else if (cmd_disec) begin
      if (cmd_data[0]) ibi_en <= 1'b0;
      if (cmd_data[3]) hj_en  <= 1'b0;
    end else if (cmd_enec) begin
      if (cmd_data[0]) ibi_en <= 1'b1;
      if (cmd_data[3]) hj_en  <= 1'b1;
    end
  end

  // Request sequencer: latch winner, wait for bus idle, issue, then grant / retry / drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      win_ptr    <= '0;
      win_hj     <= 1'b0;
      retry_cnt  <= '0;
      bo_cnt     <= '0;
      eng_start  <= 1'b0;
      eng_type   <= 1'b0;
      eng_mdb    <= 8'h00;
      ibi_gnt    <= '0;
      hj_gnt     <= 1'b0;
      ev_drop    <= 1'b0;
      ev_drop_id <= '0;
      busy       <= 1'b0;
`ifdef I3C_IBI_TIMEOUT_EN
      wd_cnt     <= '0;
`endif
    end else begin
      eng_start <= 1'b0;
      ibi_gnt   <= '0;
      hj_gnt    <= 1'b0;
      ev_drop   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hj_elig || rr_found) begin
            win_hj    <= hj_elig;
            win_ptr   <= rr_sel;
            eng_type  <= hj_elig;
            eng_mdb   <= hj_elig ? 8'h00 : sel_mdb;
            retry_cnt <= '0;
            busy      <= 1'b1;
            state     <= S_WAIT_FREE;
          end
        end
        S_WAIT_FREE: begin
          if (!win_elig) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (idle_cnt == IC_W'(IDLE_CYCLES)) begin
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          eng_start <= 1'b1;
`ifdef I3C_IBI_TIMEOUT_EN
          wd_cnt    <= '0;
`endif
          state     <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (eng_done && eng_ack) begin
            if (win_hj) begin
              hj_gnt <= 1'b1;
            end else begin
              ibi_gnt <= NUM_REQ'(1) << win_ptr;
              rr_ptr  <= rr_next;
            end
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (attempt_nack) begin
            if (retry_next == RC_W'(MAX_RETRY)) begin
              ev_drop    <= 1'b1;
              ev_drop_id <= win_hj ? ID_W'(NUM_REQ) : ID_W'(win_ptr);
              if (!win_hj) rr_ptr <= rr_next;
              busy       <= 1'b0;
              state      <= S_IDLE;
            end else begin
              retry_cnt <= retry_next;
              bo_cnt    <= '0;
              state     <= S_BACKOFF;
            end
          end
`ifdef I3C_IBI_TIMEOUT_EN
          else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        S_BACKOFF: begin
          if (bo_cnt == IC_W'(IDLE_CYCLES - 1)) begin
            state <= S_WAIT_FREE;
          end else begin
            bo_cnt <= bo_cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
